// File: rtl/mmio_io_unit.sv
// Memory-mapped I/O block on the shared load/store bus: output port, synchronised
// input port, free-running timer and a FIFO-buffered 8N1 serial transmitter.
module mmio_io_unit #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_access_addr,
    input  logic [15:0] mem_in,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [15:0] io_read_data,
    output logic [15:0] port_out,
    input  logic [15:0] port_in,
    output logic        tx_serial
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic          sel;
    logic [2:0]    idx;
    logic          wr_sel;
    logic [15:0]   sync1, sync2;
    logic [15:0]   timer;
    logic          timer_wrap, tx_overflow;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_full, fifo_empty;
    logic          push_req, push, pop, overflow_evt;
    logic          wrap_evt;
    tx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_end;
    logic          tx_busy;
    logic [15:0]   status;
    logic [15:0]   reg_val;

    assign sel    = mem_access_addr[15] & (mem_access_addr[14:3] == 12'd0);
    assign idx    = mem_access_addr[2:0];
    assign wr_sel = mem_write_en & sel;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bit_end      = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign pop          = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign push_req     = wr_sel & (idx == 3'd3);
    assign push         = push_req & (~fifo_full | pop);
    assign overflow_evt = push_req & fifo_full & ~pop;
    assign wrap_evt     = ~(wr_sel & (idx == 3'd2)) & (timer == 16'hFFFF);

    assign tx_busy = (state != IDLE);
    assign status  = {11'd0, tx_overflow, timer_wrap, tx_busy, fifo_empty, fifo_full};

    always_comb begin
        reg_val = 16'd0;
        case (idx)
            3'd0:    reg_val = port_out;
            3'd1:    reg_val = sync2;
            3'd2:    reg_val = timer;
            3'd4:    reg_val = status;
            default: reg_val = 16'd0;
        endcase
        io_read_data = (mem_read_en & sel) ? reg_val : 16'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out    <= 16'd0;
            sync1       <= 16'd0;
            sync2       <= 16'd0;
            timer       <= 16'd0;
            timer_wrap  <= 1'b0;
            tx_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            sync1 <= port_in;
            sync2 <= sync1;
            if (wr_sel && idx == 3'd0) port_out <= mem_in;
            timer <= (wr_sel && idx == 3'd2) ? mem_in : timer + 16'd1;
            // A set event in the same cycle as a W1C clear takes priority.
            if (wrap_evt)                             timer_wrap <= 1'b1;
            else if (wr_sel && idx == 3'd4 && mem_in[3]) timer_wrap <= 1'b0;
            if (overflow_evt)                         tx_overflow <= 1'b1;
            else if (wr_sel && idx == 3'd4 && mem_in[4]) tx_overflow <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= mem_in[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    if (pop) begin
                        shift     <= fifo_mem[rd_ptr[AW-1:0]];
                        bit_cnt   <= 3'd0;
                        clk_cnt   <= '0;
                        state     <= START;
                        tx_serial <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        state     <= DATA;
                        tx_serial <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            shift     <= shift >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx_serial <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        // Back-to-back frames: reload straight into START, no idle gap.
                        if (pop) begin
                            shift     <= fifo_mem[rd_ptr[AW-1:0]];
                            bit_cnt   <= 3'd0;
                            state     <= START;
                            tx_serial <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            tx_serial <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/mmio_io_unit.md
Name: mmio_io_unit

Overview:
- Memory-mapped I/O peripheral block that sits beside the data memory on the shared load/store bus.
- Claims every access with mem_access_addr[15]=1, which the data memory ignores.
- Provides:
  - a 16-bit output port
  - a synchronised 16-bit input port
  - a free-running timer
  - a FIFO-buffered 8N1 serial transmitter
- The CPU read mux ORs io_read_data with the data memory's mem_out.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥2.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_access_addr  input  16  shared load/store address.
- mem_in  input  16  store data.
- mem_write_en  input  1  store strobe.
- mem_read_en  input  1  load strobe.
- io_read_data  output  16  load data; 0 when not selected.
- port_out  output  16  output port register.
- port_in  input  16  asynchronous external input port.
- tx_serial  output  1  serial line; idles high.

Behaviour:
- Decode:
  - sel = addr[15] & (addr[14:3] == 0).
  - reg index = addr[2:0].
  - Indices 5–7, and any address with addr[15]=1 but sel=0, read 0; writes to them are ignored.
- Register map:
  - 0x8000 OUT (R/W): reads return port_out.
  - 0x8001 IN (R): returns sync2 of port_in; writes ignored.
  - 0x8002 TIMER (R/W): write loads the counter.
  - 0x8003 TXDATA (W): push mem_in[7:0] into the FIFO; reads return 0.
  - 0x8004 STATUS (R/W1C): see bit layout below.
- STATUS bits:
  - bit0 fifo_full
  - bit1 fifo_empty
  - bit2 tx_busy
  - bit3 timer_wrap (sticky)
  - bit4 tx_overflow (sticky)
  - bits 15:5 read 0
  - Writing 1 to bit3 or bit4 clears that bit; other STATUS bits ignore writes.
- Reads are combinational, zero latency:
  - io_read_data = (mem_read_en & sel) ? reg : 16'd0.
- Writes take effect on the rising edge where mem_write_en & sel.
- Reset (asynchronous, immediate) sets:
  - port_out = 0, timer = 0
  - sync flops = 0
  - FIFO empty, pointers 0
  - sticky bits = 0
  - FSM = IDLE, tx_serial = 1
  - Reset asserted mid-frame aborts the frame; tx_serial goes to 1 immediately.
- Input sync: a port_in change is visible on IN after 2 clk edges.
- Timer:
  - Increments by 1 every cycle and wraps 0xFFFF→0x0000.
  - The wrap transition sets timer_wrap.
  - A TIMER write loads mem_in in place of the increment that cycle; a load never sets timer_wrap.
  - If a wrap and a W1C clear of bit3 occur in the same cycle, set wins.
- FIFO (FIFO_DEPTH × 8 bits):
  - Push when TXDATA is written and the FIFO is not full.
  - Write while full: data dropped and tx_overflow set.
  - A pop and a push in the same cycle are both performed, even when full at the start of the cycle.
  - tx_overflow set/clear collision: set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_serial=1. If FIFO not empty, pop into the shift register, bit counter=0, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial = shift[0]; after CLKS_PER_BIT cycles shift right and bit counter+1; after the 8th bit go to STOP. Data is sent LSB first.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. Then, if FIFO not empty, pop and go directly to START; else go to IDLE.
  - tx_busy = (state != IDLE).
  - Frame length is exactly 10·CLKS_PER_BIT cycles.
  - The first start bit appears on the edge after the push lands (IDLE pop cycle + 1).
- tx_serial is driven from a register; no combinational glitches.

Test Plan:
- Reset, then write 0x8000←0xA5A5 and read 0x8000 → port_out=0xA5A5 next edge; read returns 0xA5A5; read of 0x0000–0x7FFF or 0x8005 → io_read_data=0.
- port_in 0x0000→0x1234 → IN reads 0x0000 after 1 edge and 0x1234 after 2 edges.
- Write TIMER←0xFFFE → TIMER reads 0xFFFF then 0x0000; STATUS bit3=1. Write STATUS←0x0008 → bit3=0. Load 0xFFFF while bit3 clear → no set until the next increment wraps.
- CLKS_PER_BIT=4: push 0x55 → tx_serial sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; tx_busy high for 40 cycles; STATUS bit1 returns to 1 after the pop.
- Push 6 bytes back-to-back with FIFO_DEPTH=4 while the first frame is in flight → 1 byte in the shifter, 4 in the FIFO, 6th write dropped; full=1 and overflow=1. All 5 accepted bytes are sent with no idle gap between frames.
- Assert reset mid-DATA → tx_serial=1 immediately, tx_busy=0, STATUS=0x0002, port_out=0, timer=0.
